// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command sequencer that sits directly upstream of a 4-bit combinational ALU.
// It accepts commands over a valid/ready port and keeps a 4 x 4-bit register
// file. For each command it either loads an immediate or drives registered
// operands/select to the ALU. It captures the ALU result and flags, writes
// the result back, and presents it on a valid/ready response port.
//
// Optional feature: define ALU_SEQ_SKID_EN to add a 1-entry command buffer.
// The buffer accepts a command while an operation is in flight and issues it
// on the response handshake.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   ena                global enable; low freezes all state, forces cmd_ready=0
//   cmd_valid/ready    command handshake
//   cmd_load           1 = load cmd_imm into rd, 0 = ALU op
//   cmd_op             ALU select (00 add, 01 sub, 10 and, 11 or)
//   cmd_bsel           operand B source: 0 = rf[rs2], 1 = cmd_imm
//   cmd_rd/rs1/rs2     register indices
//   cmd_imm            immediate
//   alu_a/alu_b/alu_sel  registered ALU operands and select
//   alu_out, alu_carry, alu_zero, alu_sign  ALU result and flags
//   res_valid/ready    response handshake
//   res_data           result value
//   res_flags          {sign, zero, carry}
// -----------------------------------------------------------------------------
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bsel,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_flags
);

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned RF_DEPTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic              load;
    logic [SEL_W-1:0]  op;
    logic              bsel;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs1;
    logic [IDX_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  // State and datapath registers
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_rf [RF_DEPTH];
  logic [IDX_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [SEL_W-1:0]  r_alu_sel;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [FLAG_W-1:0] r_res_flags;

  // Combinational decode
  cmd_t              w_cmd_in;
  cmd_t              w_issue_cmd;
  logic              w_cmd_ready;
  logic              w_cmd_fire;
  logic              w_res_fire;
  logic              w_issue;

  // Next-state values
  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  w_rd_nxt;
  logic [DATA_W-1:0] w_alu_a_nxt;
  logic [DATA_W-1:0] w_alu_b_nxt;
  logic [SEL_W-1:0]  w_alu_sel_nxt;
  logic              w_res_valid_nxt;
  logic [DATA_W-1:0] w_res_data_nxt;
  logic [FLAG_W-1:0] w_res_flags_nxt;
  logic              w_rf_we;
  logic [IDX_W-1:0]  w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

`ifdef ALU_SEQ_SKID_EN
  cmd_t              r_buf;
  logic              r_buf_valid;
  logic              w_buf_load;
  logic              w_buf_clear;
`endif

  // Pack the command port into one payload
  assign w_cmd_in = '{
    load: cmd_load,
    op:   cmd_op,
    bsel: cmd_bsel,
    rd:   cmd_rd,
    rs1:  cmd_rs1,
    rs2:  cmd_rs2,
    imm:  cmd_imm
  };

  // Command-ready: never during reset or while disabled
  always_comb begin
    w_cmd_ready = 1'b0;
    if (rst_n && ena) begin
`ifdef ALU_SEQ_SKID_EN
      w_cmd_ready = (r_state == ST_IDLE) || !r_buf_valid;
`else
      w_cmd_ready = (r_state == ST_IDLE);
`endif
    end
  end

  assign w_cmd_fire = cmd_valid && w_cmd_ready;
  assign w_res_fire = rst_n && ena && (r_state == ST_RESP) && r_res_valid && res_ready;

  // Issue select: from the port in IDLE. With the skid buffer enabled, a
  // command can also issue on the response handshake, buffered entry first.
  always_comb begin
    w_issue     = 1'b0;
    w_issue_cmd = w_cmd_in;
`ifdef ALU_SEQ_SKID_EN
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
`endif
    if (r_state == ST_IDLE) begin
      w_issue = w_cmd_fire;
    end
`ifdef ALU_SEQ_SKID_EN
    else begin
      if (w_res_fire && r_buf_valid) begin
        w_issue     = 1'b1;
        w_issue_cmd = r_buf;
        w_buf_clear = 1'b1;
      end else if (w_res_fire && w_cmd_fire) begin
        // Empty buffer and a command arriving on the handshake edge: the
        // command passes straight through, which keeps program order.
        w_issue = 1'b1;
      end else if (w_cmd_fire) begin
        w_buf_load = 1'b1;
      end
    end
`endif
  end

  // Next-state and register-update decode
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_nxt        = r_rd;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_sel_nxt   = r_alu_sel;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;
    w_res_flags_nxt = r_res_flags;
    w_rf_we         = 1'b0;
    w_rf_waddr      = r_rd;
    w_rf_wdata      = alu_out;

    case (r_state)
      ST_EXEC: begin
        // ALU output has settled; capture and write back
        w_rf_we         = 1'b1;
        w_rf_waddr      = r_rd;
        w_rf_wdata      = alu_out;
        w_res_data_nxt  = alu_out;
        w_res_flags_nxt = {alu_sign, alu_zero, alu_carry};
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end
      ST_RESP: begin
        if (w_res_fire) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    // Issue only happens from IDLE or RESP, so it never collides with EXEC
    if (w_issue) begin
      if (w_issue_cmd.load) begin
        w_rf_we         = 1'b1;
        w_rf_waddr      = w_issue_cmd.rd;
        w_rf_wdata      = w_issue_cmd.imm;
        w_res_data_nxt  = w_issue_cmd.imm;
        w_res_flags_nxt = {w_issue_cmd.imm[DATA_W-1],
                           (w_issue_cmd.imm == DATA_W'(0)), 1'b0};
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end else begin
        // Any earlier writeback has already landed, so rf reads are current
        w_alu_a_nxt   = r_rf[w_issue_cmd.rs1];
        w_alu_b_nxt   = w_issue_cmd.bsel ? w_issue_cmd.imm : r_rf[w_issue_cmd.rs2];
        w_alu_sel_nxt = w_issue_cmd.op;
        w_rd_nxt      = w_issue_cmd.rd;
        w_state_nxt   = ST_EXEC;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, register file and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf        <= '{default: '0};
      r_rd        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else if (ena) begin
      if (w_rf_we) begin
        r_rf[w_rf_waddr] <= w_rf_wdata;
      end
      r_rd        <= w_rd_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_sel   <= w_alu_sel_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_flags <= w_res_flags_nxt;
    end
  end

`ifdef ALU_SEQ_SKID_EN
  // One-entry command buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (ena) begin
      if (w_buf_load) begin
        r_buf_valid <= 1'b1;
        r_buf       <= w_cmd_in;
      end else if (w_buf_clear) begin
        r_buf_valid <= 1'b0;
      end
    end
  end
`endif

  assign cmd_ready = w_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer that sits directly upstream of the 4-bit ALU and consumes its results. It accepts operation commands over a valid/ready handshake and holds a 4-entry × 4-bit register file. It drives registered operands and select to the ALU, captures the ALU result and flags, and writes the result back to the register file. It then presents the result on a valid/ready response port.

## Interface
Parameters:
- none; widths are fixed to the ALU's 4-bit datapath.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- ena  in  1  global enable; low freezes all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
- cmd_load  in  1  1 = load cmd_imm into rd (no ALU op); 0 = ALU op
- cmd_op  in  2  ALU select: 00 add, 01 sub, 10 and, 11 or
- cmd_bsel  in  1  operand B source: 0 = rf[rs2], 1 = cmd_imm
- cmd_rd, cmd_rs1, cmd_rs2  in  2 each  destination/source register indices
- cmd_imm  in  4  immediate
- alu_a, alu_b  out  4 each  registered ALU operands
- alu_sel  out  2  registered ALU select
- alu_out  in  4  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_carry, alu_zero, alu_sign  in  1 each  ALU flags
- res_valid  out  1  response present
- res_ready  in  1  response consumed when res_valid & res_ready at rising edge
- res_data  out  4  result value
- res_flags  out  3  {sign, zero, carry}

## Operation
- Three states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On an ALU command accept: alu_a <= rf[rs1], alu_b <= (bsel ? imm : rf[rs2]), alu_sel <= op, latch rd; go to EXEC.
  - On a load accept: rf[rd] <= imm, res_data <= imm, res_flags <= {imm[3], imm==0, 0}, res_valid <= 1; go to RESP.
- EXEC:
  - cmd_ready = 0. The ALU settles during this cycle.
  - At the edge: res_data <= alu_out, res_flags <= {alu_sign, alu_zero, alu_carry}, rf[rd] <= alu_out, res_valid <= 1; go to RESP.
- RESP:
  - res_valid = 1.
  - res_data and res_flags stay stable until res_ready.
  - On handshake: res_valid <= 0; go to IDLE, or issue from the skid buffer when it is enabled.
- Operands are read from the register file only after any prior writeback completes, so there are no read-after-write hazards.
- rs1 == rs2 == rd is legal.
- alu_a, alu_b and alu_sel hold their last values outside EXEC.
- ena low:
  - No state, register-file or output-register change.
  - cmd_ready is forced to 0.
  - res_valid holds its value; a res_ready pulse is ignored.
- Reset values:
  - state = IDLE, all rf entries = 0.
  - alu_a = alu_b = 0, alu_sel = 00.
  - res_valid = 0, res_data = 0, res_flags = 000.
  - cmd_ready = 0 during reset and 1 on the first cycle after it (when ena = 1).
- Reset in any state aborts the operation: no writeback and no response; any buffered command is dropped.

## Timing
- ALU command: accepted at edge N; alu_* valid after N; result captured at N+1; res_valid high after N+1. Latency is 2 cycles.
- Load: res_valid high after edge N. Latency is 1 cycle.
- Maximum throughput without skid: one ALU command per 3 cycles (accept, EXEC, RESP handshake) with res_ready held at 1.
- A response handshake and a new command accept never occur on the same edge in the base configuration, because cmd_ready = 0 in RESP.

## Configuration
- ALU_SEQ_SKID_EN defined:
  - Adds a 1-entry command buffer.
  - cmd_ready = 1 in EXEC/RESP while the buffer is empty.
  - A command accepted in EXEC/RESP is held in the buffer.
  - On the RESP handshake, a buffered command issues exactly as from IDLE (operands read after writeback), and the buffer empties on that same edge.
  - Buffered commands are never reordered.
  - Throughput: one ALU command per 2 cycles.
- ALU_SEQ_SKID_EN undefined: no buffer; cmd_ready = 1 only in IDLE.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with random command stimulus -> all outputs 0; after release, cmd_ready = 1 and rf reads 0 (add r0 = r1 + r2 returns data 0, flags 010).
- Load r0 = 9, r1 = 7, then add r2 = r0 + r1 -> res_data 0x0, flags {0,1,1}; res_valid exactly 2 cycles after accept; alu_a = 9, alu_b = 7, alu_sel = 00 during EXEC.
- Sub r3 = r1 - r0 (7 - 9) -> res_data 0xE, flags {1,0,1}. Then or r3 with imm 0x1 (bsel = 1) -> 0xF, flags {1,0,0}.
- Backpressure: hold res_ready = 0 for 5 cycles -> res_data and res_flags stable and res_valid = 1 throughout. Without skid, cmd_ready = 0 throughout. With skid, exactly one more command is accepted, then cmd_ready = 0; the buffered command's result follows in order.
- Reset mid-EXEC of add r2 = r0 + r1 -> no response; r2 reads 0 afterwards.
- ena = 0 for 3 cycles during EXEC -> no state change and cmd_ready = 0; the result appears 1 cycle after ena returns to 1.
